// File: rtl/cache_lookup_ctrl_if.sv
// Request, response, refill and SRAM-array signals of the cache lookup controller.
// Latency: wires only. Backpressure: valid/ready on request, response and refill-request channels.
// Ports: master = controller side, slave = CPU / memory / SRAM environment side.
interface cache_lookup_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512
);
    // CPU request / response
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_hit_o;
    logic [LINE_W-1:0] rsp_data_o;
    // Refill path to memory
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rsp_valid_i;
    logic [LINE_W-1:0] mem_rsp_data_i;
    // Dual-port tag/data array
    logic              rden_o;
    logic [7:0]        raddr_o;
    logic [18:0]       rdata_tag0_i;
    logic [18:0]       rdata_tag1_i;
    logic [LINE_W-1:0] rdata_data0_i;
    logic [LINE_W-1:0] rdata_data1_i;
    logic              wren_o;
    logic [7:0]        waddr_o;
    logic              wway_o;
    logic [18:0]       wdata_tag_o;
    logic [LINE_W-1:0] wdata_data_o;

    modport master (
        input  req_valid_i, req_addr_i, rsp_ready_i,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  rdata_tag0_i, rdata_tag1_i, rdata_data0_i, rdata_data1_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_data_o,
        output mem_req_valid_o, mem_addr_o,
        output rden_o, raddr_o, wren_o, waddr_o, wway_o, wdata_tag_o, wdata_data_o
    );

    modport slave (
        output req_valid_i, req_addr_i, rsp_ready_i,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        output rdata_tag0_i, rdata_tag1_i, rdata_data0_i, rdata_data1_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_data_o,
        input  mem_req_valid_o, mem_addr_o,
        input  rden_o, raddr_o, wren_o, waddr_o, wway_o, wdata_tag_o, wdata_data_o
    );
endinterface

// File: rtl/cache_lookup_ctrl.sv
// Read-only 2-way/256-set cache lookup controller: tag compare, refill on miss, LRU replacement.
// Latency: hit response 3 cycles after acceptance; miss response 2 cycles after refill data.
// Backpressure: one request in flight; req_ready_o low until the response is accepted.
// Ports: clk, rst_n (async active-low), bus (cache_lookup_ctrl_if.master).
// Optional CACHE_LOOKUP_STATS_EN adds saturating hit_cnt_o / miss_cnt_o counters.
module cache_lookup_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    cache_lookup_ctrl_if.master bus
`ifdef CACHE_LOOKUP_STATS_EN
    ,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
`endif
);
    localparam int TAG_W = 18;
    localparam int IDX_W = 8;
    localparam int OFF_W = 6;

    typedef enum logic [2:0] {
        IDLE, RD, CMP, MREQ, MWAIT, FILL, RSP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:OFF_W]   line_q;      // line address of the request in flight
    logic                    victim_q;
    logic [(1<<IDX_W)-1:0]   lru_q;       // per set: way to evict when both are valid
    logic [LINE_W-1:0]       rsp_data_q;
    logic                    rsp_hit_q;

    logic [TAG_W-1:0]        cur_tag;
    logic [IDX_W-1:0]        cur_idx;
    logic                    hit0, hit1, any_hit, hit_way, victim_c;

    assign cur_tag = line_q[ADDR_W-1:OFF_W+IDX_W];
    assign cur_idx = line_q[OFF_W+IDX_W-1:OFF_W];

    // Array outputs are only meaningful in CMP; these terms are ignored elsewhere.
    assign hit0    = bus.rdata_tag0_i[TAG_W] & (bus.rdata_tag0_i[TAG_W-1:0] == cur_tag);
    assign hit1    = bus.rdata_tag1_i[TAG_W] & (bus.rdata_tag1_i[TAG_W-1:0] == cur_tag);
    assign any_hit = hit0 | hit1;
    assign hit_way = hit0 ? 1'b0 : 1'b1;   // a corrupt double hit resolves to way 0

    // Fill an invalid way first; only consult LRU when the set is full.
    assign victim_c = !bus.rdata_tag0_i[TAG_W] ? 1'b0 :
                      !bus.rdata_tag1_i[TAG_W] ? 1'b1 : lru_q[cur_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            line_q     <= '0;
            victim_q   <= 1'b0;
            lru_q      <= '0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        line_q <= bus.req_addr_i[ADDR_W-1:OFF_W];
                    end
                end
                CMP: begin
                    if (any_hit) begin
                        rsp_data_q     <= hit0 ? bus.rdata_data0_i : bus.rdata_data1_i;
                        rsp_hit_q      <= 1'b1;
                        lru_q[cur_idx] <= ~hit_way;
                    end else begin
                        victim_q <= victim_c;
                    end
                end
                MWAIT: begin
                    if (bus.mem_rsp_valid_i) begin
                        rsp_data_q <= bus.mem_rsp_data_i;
                        rsp_hit_q  <= 1'b0;
                    end
                end
                FILL: begin
                    lru_q[cur_idx] <= ~victim_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d             = state_q;
        bus.req_ready_o     = 1'b0;
        bus.rsp_valid_o     = 1'b0;
        bus.mem_req_valid_o = 1'b0;
        bus.mem_addr_o      = '0;
        bus.rden_o          = 1'b0;
        bus.raddr_o         = '0;
        bus.wren_o          = 1'b0;
        bus.waddr_o         = '0;
        bus.wway_o          = 1'b0;
        bus.wdata_tag_o     = '0;
        bus.wdata_data_o    = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) state_d = RD;
            end
            RD: begin
                bus.rden_o  = 1'b1;
                bus.raddr_o = cur_idx;
                state_d     = CMP;
            end
            CMP: begin
                state_d = any_hit ? RSP : MREQ;
            end
            MREQ: begin
                bus.mem_req_valid_o = 1'b1;
                bus.mem_addr_o      = {line_q, {OFF_W{1'b0}}};
                if (bus.mem_req_ready_i) state_d = MWAIT;
            end
            MWAIT: begin
                if (bus.mem_rsp_valid_i) state_d = FILL;
            end
            FILL: begin
                // The refill line already sits in the response register.
                bus.wren_o       = 1'b1;
                bus.waddr_o      = cur_idx;
                bus.wway_o       = victim_q;
                bus.wdata_tag_o  = {1'b1, cur_tag};
                bus.wdata_data_o = rsp_data_q;
                state_d          = RSP;
            end
            RSP: begin
                bus.rsp_valid_o = 1'b1;
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rsp_data_o = rsp_data_q;
    assign bus.rsp_hit_o  = rsp_hit_q;

`ifdef CACHE_LOOKUP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state_q == CMP) begin
            if (any_hit) begin
                if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
                if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Bench for cache_lookup_ctrl: SRAM array model, memory responder and a set/way cache reference.
// Latency: checked per transaction against the hit/miss response timing.
// Backpressure: random mem_req_ready_i and rsp_ready_i stalls.
module tb_cache_lookup_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_lookup_ctrl_if bus ();

`ifdef CACHE_LOOKUP_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    cache_lookup_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CACHE_LOOKUP_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    // SRAM array: read data appears the cycle after rden_o, writes commit on the clock edge.
    bit [18:0]  arr_tag  [2][256];
    bit [511:0] arr_data [2][256];
    always @(posedge clk) begin
        if (bus.rden_o) begin
            bus.rdata_tag0_i  <= arr_tag[0][bus.raddr_o];
            bus.rdata_tag1_i  <= arr_tag[1][bus.raddr_o];
            bus.rdata_data0_i <= arr_data[0][bus.raddr_o];
            bus.rdata_data1_i <= arr_data[1][bus.raddr_o];
        end
        if (bus.wren_o) begin
            arr_tag[bus.wway_o][bus.waddr_o]  <= bus.wdata_tag_o;
            arr_data[bus.wway_o][bus.waddr_o] <= bus.wdata_data_o;
        end
    end

    // Reference cache contents: per set, two ways and the way to evict next.
    bit         ref_vld [2][256];
    bit [17:0]  ref_tag [2][256];
    bit [511:0] ref_dat [2][256];
    bit         ref_evict [256];
    int         exp_hits = 0;
    int         exp_miss = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [31:0] addr, input int mreq_dly, input int mrsp_dly,
                       input int rsp_dly);
        logic [17:0]  tg;
        logic [7:0]   ix;
        bit           exp_hit, hway, vway, mreq_done, mrsp_sent, done;
        logic [511:0] fill, exp_data;
        int cyc, rden_cyc, rsp_cyc, mrsp_cyc, mreq_wait, mrsp_gap, rsp_wait, mreq_cnt, wren_cnt;
        tg = addr[31:14];
        ix = addr[13:6];
        exp_hit = 1'b0;
        hway    = 1'b0;
        if (ref_vld[0][ix] && ref_tag[0][ix] == tg) begin
            exp_hit = 1'b1; hway = 1'b0;
        end else if (ref_vld[1][ix] && ref_tag[1][ix] == tg) begin
            exp_hit = 1'b1; hway = 1'b1;
        end
        if (!ref_vld[0][ix])      vway = 1'b0;
        else if (!ref_vld[1][ix]) vway = 1'b1;
        else                      vway = ref_evict[ix];
        for (int k = 0; k < 16; k++) fill[k*32 +: 32] = $urandom;
        exp_data = exp_hit ? ref_dat[hway][ix] : fill;

        @(negedge clk);
        chk("req_ready_idle", bus.req_ready_o, 1);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = $urandom;

        cyc = 0; rden_cyc = -1; rsp_cyc = -1; mrsp_cyc = -1;
        mreq_wait = 0; mrsp_gap = 0; rsp_wait = 0; mreq_cnt = 0; wren_cnt = 0;
        mreq_done = 1'b0; mrsp_sent = 1'b0; done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus.mem_rsp_valid_i = 1'b0;
            chk("rden_wren_excl", bus.rden_o & bus.wren_o, 0);
            if (cyc == 1) begin
                // stray refill beat outside MWAIT must be ignored
                bus.mem_rsp_valid_i = 1'b1;
                bus.mem_rsp_data_i  = ~exp_data;
            end
            if (bus.rden_o) begin
                if (rden_cyc < 0) rden_cyc = cyc;
                chk("raddr", bus.raddr_o, ix);
            end
            if (bus.mem_req_valid_o) begin
                mreq_cnt++;
                chk("mem_addr", bus.mem_addr_o, {addr[31:6], 6'b0});
                if (mreq_wait >= mreq_dly) begin
                    bus.mem_req_ready_i = 1'b1;
                    mreq_done = 1'b1;
                end else begin
                    bus.mem_req_ready_i = 1'b0;
                    mreq_wait++;
                end
            end else begin
                bus.mem_req_ready_i = 1'b0;
                if (mreq_done && !mrsp_sent) begin
                    if (mrsp_gap >= mrsp_dly) begin
                        bus.mem_rsp_valid_i = 1'b1;
                        bus.mem_rsp_data_i  = fill;
                        mrsp_sent = 1'b1;
                        mrsp_cyc  = cyc;
                    end else begin
                        mrsp_gap++;
                    end
                end
            end
            if (bus.wren_o) begin
                wren_cnt++;
                chk("waddr", bus.waddr_o, ix);
                chk("wway", bus.wway_o, vway);
                chk("wdata_tag", bus.wdata_tag_o, {1'b1, tg});
                chk("wdata_data", bus.wdata_data_o, fill);
            end
            if (bus.rsp_valid_o) begin
                if (rsp_cyc < 0) rsp_cyc = cyc;
                chk("rsp_data", bus.rsp_data_o, exp_data);
                chk("rsp_hit", bus.rsp_hit_o, exp_hit);
                chk("req_ready_busy", bus.req_ready_o, 0);
                if (rsp_wait >= rsp_dly) begin
                    bus.rsp_ready_i = 1'b1;
                    done = 1'b1;
                end else begin
                    bus.rsp_ready_i = 1'b0;
                    rsp_wait++;
                end
            end
        end
        chk("txn_completed", done, 1);
        @(posedge clk);
        #1;
        bus.rsp_ready_i     = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;

        chk("rden_cycle", rden_cyc, 1);
        if (exp_hit) begin
            chk("hit_rsp_cycle", rsp_cyc, 3);
            chk("hit_no_mem_req", mreq_cnt, 0);
            chk("hit_no_wren", wren_cnt, 0);
            ref_evict[ix] = ~hway;
            exp_hits++;
        end else begin
            chk("miss_rsp_cycle", rsp_cyc, mrsp_cyc + 2);
            chk("miss_mem_req_cycles", mreq_cnt, mreq_dly + 1);
            chk("miss_one_wren", wren_cnt, 1);
            ref_vld[vway][ix] = 1'b1;
            ref_tag[vway][ix] = tg;
            ref_dat[vway][ix] = fill;
            ref_evict[ix]     = ~vway;
            exp_miss++;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  rix;
        int          seen, wr_cnt, rv_cnt;

        bus.req_valid_i     = 1'b0;
        bus.req_addr_i      = '0;
        bus.rsp_ready_i     = 1'b0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready_o, 1);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_hit", bus.rsp_hit_o, 0);
        chk("rst_rsp_data", bus.rsp_data_o, 0);
        chk("rst_mem_req_valid", bus.mem_req_valid_o, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_rden", bus.rden_o, 0);
        chk("rst_wren", bus.wren_o, 0);
        rst_n = 1'b1;

        // Directed: cold miss, hit, second way, LRU update, eviction with backpressure
        txn(32'h0000_1240, 0, 2, 0);
        txn(32'h0000_1240, 0, 0, 0);
        txn(32'h0000_5240, 1, 0, 1);
        txn(32'h0000_127C, 0, 0, 0);
        txn(32'h0000_9240, 5, 1, 4);
`ifdef CACHE_LOOKUP_STATS_EN
        chk("stats_hits_dir", hit_cnt, exp_hits);
        chk("stats_miss_dir", miss_cnt, exp_miss);
`endif

        // Random traffic on a few sets with a small tag pool
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       rix = 8'h49;
                1:       rix = 8'h00;
                2:       rix = 8'hFF;
                default: rix = 8'h22;
            endcase
            a = {18'($urandom_range(0, 3)), rix, 6'($urandom)};
            txn(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
`ifdef CACHE_LOOKUP_STATS_EN
        chk("stats_hits_rand", hit_cnt, exp_hits);
        chk("stats_miss_rand", miss_cnt, exp_miss);
`endif

        // Reset while waiting for refill data
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'hFFFF_DDC0;   // tag 3FFFF, set 0x77: a cold miss
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.mem_req_valid_o) begin
                seen = 1;
                bus.mem_req_ready_i = 1'b1;
            end
        end
        chk("abort_mem_req_seen", seen, 1);
        @(negedge clk);
        bus.mem_req_ready_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", bus.req_ready_o, 1);
        chk("abort_rsp_valid", bus.rsp_valid_o, 0);
        chk("abort_rsp_data", bus.rsp_data_o, 0);
        chk("abort_mem_req_valid", bus.mem_req_valid_o, 0);
        chk("abort_mem_addr", bus.mem_addr_o, 0);
        chk("abort_wren", bus.wren_o, 0);
        chk("abort_rden", bus.rden_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 256; s++) ref_evict[s] = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        @(negedge clk);
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = {16{32'hDEAD_BEEF}};
        wr_cnt = 0;
        rv_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.mem_rsp_valid_i = 1'b0;
            if (bus.wren_o)      wr_cnt++;
            if (bus.rsp_valid_o) rv_cnt++;
        end
        chk("stray_no_wren", wr_cnt, 0);
        chk("stray_no_rsp", rv_cnt, 0);
`ifdef CACHE_LOOKUP_STATS_EN
        chk("stats_hits_reset", hit_cnt, 0);
        chk("stats_miss_reset", miss_cnt, 0);
`endif

        // Aborted line was never written; set 0x49 eviction restarts from cleared LRU
        txn(32'hFFFF_DDC0, 0, 0, 0);
        txn(32'h0003_1240, 2, 0, 0);
        txn(32'h0003_1240, 0, 0, 2);
`ifdef CACHE_LOOKUP_STATS_EN
        chk("stats_hits_end", hit_cnt, exp_hits);
        chk("stats_miss_end", miss_cnt, exp_miss);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_lookup_ctrl.md
Name: cache_lookup_ctrl

Overview:
- Initiator side of the 2-way, 256-set cache tag/data SRAM array.
- Accepts 32-bit read requests, issues array reads, compares tags and returns the 512-bit line on a hit.
- On a miss, fetches the line from memory, writes it to an invalid or LRU way, then responds.
- Sits between the CPU-side request port and the dual-port SRAM array; the cache is read-only (no write or dirty handling).

Parameters:
- ADDR_W, 32, request address width; fixed split is tag[31:14], index[13:6], offset[5:0].
- LINE_W, 512, line width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_addr_i  in  32  byte address
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_hit_o  out  1  1 = hit, 0 = served by refill
- rsp_data_o  out  512  line data
- mem_req_valid_o  out  1  refill request valid
- mem_req_ready_i  in  1  refill request accepted
- mem_addr_o  out  32  line-aligned refill address (offset bits 0)
- mem_rsp_valid_i  in  1  refill data valid (single beat)
- mem_rsp_data_i  in  512  refill line
- rden_o  out  1  array read enable
- raddr_o  out  8  array read index
- rdata_tag0_i  in  19  way-0 tag word {valid, tag[17:0]}
- rdata_tag1_i  in  19  way-1 tag word
- rdata_data0_i  in  512  way-0 line
- rdata_data1_i  in  512  way-1 line
- wren_o  out  1  array write enable
- waddr_o  out  8  array write index
- wway_o  out  1  write way
- wdata_tag_o  out  19  {1'b1, tag}
- wdata_data_o  out  512  fill line

Behaviour:
- Reset (async, active-low):
  - state = IDLE.
  - All outputs 0 except req_ready_o = 1.
  - 256-bit LRU vector cleared.
  - Latched address cleared.
- Array read data is valid only in the cycle after the cycle in which rden_o = 1. It is sampled only in state CMP; array outputs are don't-care otherwise.
- State machine:
  - IDLE: req_ready_o = 1. On req_valid_i & req_ready_o, latch the address and go to RD.
  - RD: rden_o = 1, raddr_o = index. Go to CMP.
  - CMP: hitN = tagN[18] & (tagN[17:0] == tag).
    - Hit (either way): register rsp_data_o from the hit way, rsp_hit_o = 1, set LRU[index] = ~hit_way, go to RSP.
    - Both ways hit (corrupt array): way 0 wins.
    - Miss: pick the victim, go to MREQ.
  - MREQ: mem_req_valid_o = 1, mem_addr_o = {tag, index, 6'b0}. Hold both until mem_req_ready_i; then go to MWAIT.
  - MWAIT: wait for mem_rsp_valid_i. Capture the data into rsp_data_o, rsp_hit_o = 0, go to FILL.
  - FILL: one cycle with wren_o = 1, waddr_o = index, wway_o = victim, wdata_tag_o = {1, tag}, wdata_data_o = captured line. Set LRU[index] = ~victim, go to RSP.
  - RSP: rsp_valid_o = 1, with data and hit held stable until rsp_ready_i. Then go to IDLE.
- Victim selection: first invalid way (way 0 before way 1); if both ways are valid, LRU[index].
- rden_o and wren_o are never asserted in the same cycle.
- A read of a set in the cycle after its FILL returns the new line (array write commits at the FILL clock edge).
- Latency (acceptance edge = cycle 0):
  - Hit: rsp_valid_o first high in cycle 3.
  - Miss: rsp_valid_o first high 2 cycles after mem_rsp_valid_i is sampled.
- mem_rsp_valid_i is ignored outside MWAIT.
- Reset mid-operation aborts the transaction with no array write. A later stray mem_rsp_valid_i is ignored.

Optional Feature:
- Macro: CACHE_LOOKUP_STATS_EN.
- When defined, adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Each increments once per CMP resolution (hit or miss respectively).
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold miss: request 0x0000_1240 after reset -> mem_addr_o = 0x0000_1240. Fill line A -> wren_o with waddr_o = 0x49, wway_o = 0, wdata_tag_o = {1, 18'h0}. Response returns rsp_hit_o = 0, data A.
- Hit: repeat 0x0000_1240 -> rden_o in cycle 1, rsp_valid_o in cycle 3, rsp_hit_o = 1, data A, no mem_req_valid_o.
- Second way, then LRU eviction, all on set 0x49:
  - Miss on 0x0000_5240 fills way 1.
  - Hit on 0x0000_1240 sets LRU[0x49] = 1.
  - Miss on 0x0000_9240 evicts way 1 (wway_o = 1).
- Backpressure:
  - mem_req_ready_i low for 5 cycles -> mem_req_valid_o and mem_addr_o held stable.
  - rsp_ready_i low for 4 cycles -> rsp_data_o held stable, req_ready_o = 0.
- Reset mid-miss: assert rst_n = 0 in MWAIT -> outputs zero immediately, req_ready_o = 1. A later mem_rsp_valid_i pulse produces no wren_o.
- Stats (macro defined): the cold-miss, hit, LRU sequence above -> hit_cnt_o = 2, miss_cnt_o = 3.
